// File: rtl/seven_segment_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_driver
// Description : Time-multiplexed hexadecimal driver for a common-anode
//               seven-segment array. A value and its decimal points are
//               latched on a load strobe; one digit is lit at a time, with a
//               single all-off cycle between digits to prevent ghosting.
//
// Parameters  : DIGITS        number of digits scanned (1..8)
//               REFRESH_BITS  refresh counter width; each digit dwell is
//                             2^REFRESH_BITS cycles including 1 blank (>= 2)
//
// Ports       : clock     in   system clock, rising edge
//               reset_n   in   synchronous active-low reset
//               load      in   capture value/dp at this edge
//               value     in   [4*DIGITS] hex nibbles, nibble 0 = rightmost
//               dp        in   [DIGITS] decimal-point enables, active-high
//               anodes    out  [DIGITS] digit enables, active-low
//               segments  out  [7] {g,f,e,d,c,b,a}, active-low
//               point     out  decimal point, active-low
//
// Options     : LEADING_ZERO_BLANK_EN  when defined, leading zero digits
//                                      (other than digit 0) are blanked
//
// Revision    : 1.0  initial release
// ============================================================================

module seven_segment_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  point
);

    // Digit index needs at least one bit even for a single-digit display.
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_IDX_W-1:0]      c_LAST_IDX    = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0]      c_IDX_ONE     = {{(c_IDX_W-1){1'b0}}, 1'b1};
    localparam logic [REFRESH_BITS-1:0] c_REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]              c_SEG_OFF     = 7'h7F;

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [c_IDX_W-1:0]      r_index;
    logic [4*DIGITS-1:0]     r_value;
    logic [DIGITS-1:0]       r_dp;
    logic [DIGITS-1:0]       r_anodes;
    logic [6:0]              r_segments;
    logic                    r_point;

    logic                    w_blank_cycle;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic [DIGITS-1:0]       w_anodes_lit;
    logic [6:0]              w_segments_lit;
    logic                    w_suppress_sel;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    f_hex_decode = 7'h40;
            4'h1:    f_hex_decode = 7'h79;
            4'h2:    f_hex_decode = 7'h24;
            4'h3:    f_hex_decode = 7'h30;
            4'h4:    f_hex_decode = 7'h19;
            4'h5:    f_hex_decode = 7'h12;
            4'h6:    f_hex_decode = 7'h02;
            4'h7:    f_hex_decode = 7'h78;
            4'h8:    f_hex_decode = 7'h00;
            4'h9:    f_hex_decode = 7'h10;
            4'hA:    f_hex_decode = 7'h08;
            4'hB:    f_hex_decode = 7'h03;
            4'hC:    f_hex_decode = 7'h46;
            4'hD:    f_hex_decode = 7'h21;
            4'hE:    f_hex_decode = 7'h06;
            default: f_hex_decode = 7'h0E;
        endcase
    endfunction

    // The last count of every dwell is the blanking slot; the index also
    // advances there so the next lit cycle already shows the new digit.
    assign w_blank_cycle = &r_refresh;

`ifdef LEADING_ZERO_BLANK_EN
    // w_suppress[i] is set when nibbles DIGITS-1 down to i are all zero.
    // Bit 0 is never set so a zero value still shows a single "0".
    logic [DIGITS-1:0] w_suppress;
    logic              w_upper_zero;

    always_comb begin
        w_upper_zero = 1'b1;
        w_suppress   = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_upper_zero  = w_upper_zero & (r_value[i*4 +: 4] == 4'h0);
            w_suppress[i] = w_upper_zero;
        end
    end
`endif

    // Select the current digit's nibble, dp bit and anode with an explicit
    // compare so an index outside 0..DIGITS-1 can never address past the
    // registers.
    always_comb begin
        w_nibble       = 4'h0;
        w_dp_bit       = 1'b0;
        w_anodes_lit   = '1;
        w_suppress_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_index == c_IDX_W'(i)) begin
                w_nibble        = r_value[i*4 +: 4];
                w_dp_bit        = r_dp[i];
                w_anodes_lit[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                w_suppress_sel  = w_suppress[i];
`endif
            end
        end
        w_segments_lit = w_suppress_sel ? c_SEG_OFF : f_hex_decode(w_nibble);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_refresh  <= '0;
            r_index    <= '0;
            r_value    <= '0;
            r_dp       <= '0;
            r_anodes   <= '1;
            r_segments <= c_SEG_OFF;
            r_point    <= 1'b1;
        end else begin
            r_refresh <= r_refresh + c_REFRESH_ONE;

            if (w_blank_cycle) begin
                r_index <= (r_index == c_LAST_IDX) ? '0 : r_index + c_IDX_ONE;
            end

            // Outputs at a load edge are built from the old contents; the
            // new value shows from the following lit cycle.
            if (load) begin
                r_value <= value;
                r_dp    <= dp;
            end

            if (w_blank_cycle) begin
                r_anodes   <= '1;
                r_segments <= c_SEG_OFF;
                r_point    <= 1'b1;
            end else begin
                r_anodes   <= w_anodes_lit;
                r_segments <= w_segments_lit;
                r_point    <= ~w_dp_bit;
            end
        end
    end

    assign anodes   = r_anodes;
    assign segments = r_segments;
    assign point    = r_point;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_driver
// Description : Scoreboard bench for seven_segment_driver (DIGITS=4,
//               REFRESH_BITS=2). The stimulus process pushes the expected
//               display state for each upcoming edge; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================

module tb_seven_segment_driver;

    localparam int c_DIGITS  = 4;
    localparam int c_RBITS   = 2;
    localparam int c_FRAME   = 16;

    logic        clock;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        point;

    seven_segment_driver #(
        .DIGITS       (c_DIGITS),
        .REFRESH_BITS (c_RBITS)
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .value    (value),
        .dp       (dp),
        .anodes   (anodes),
        .segments (segments),
        .point    (point)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [3:0] an;
        logic [6:0] seg;
        logic       pt;
    } exp_t;

    exp_t q_exp[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Bench view of what the display should currently hold:
    // {digit3,digit2,digit1,digit0} expected segment patterns and dp bits.
    logic [27:0] r_tbl;
    logic [3:0]  r_dpt;
    int          pos;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] c_TBL_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] c_TBL_0003 = {7'h7F, 7'h7F, 7'h7F, 7'h30};
    localparam logic [27:0] c_TBL_0040 = {7'h7F, 7'h7F, 7'h19, 7'h40};
`else
    localparam logic [27:0] c_TBL_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] c_TBL_0003 = {7'h40, 7'h40, 7'h40, 7'h30};
    localparam logic [27:0] c_TBL_0040 = {7'h40, 7'h40, 7'h19, 7'h40};
`endif
    localparam logic [27:0] c_TBL_1A8F = {7'h79, 7'h08, 7'h00, 7'h0E};
    localparam logic [27:0] c_TBL_FFFF = {7'h0E, 7'h0E, 7'h0E, 7'h0E};

    // Drive inputs for the next edge and push what that edge must produce.
    // ntbl is the hand-computed display table for the loaded value.
    task automatic step(input logic rn, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic [27:0] ntbl);
        exp_t e;
        int   k;
        reset_n = rn;
        load    = ld;
        value   = v;
        dp      = d;
        e.due   = cyc + 1;
        if (!rn) begin
            e.an  = 4'b1111;
            e.seg = 7'h7F;
            e.pt  = 1'b1;
            r_tbl = c_TBL_ZERO;
            r_dpt = 4'b0000;
            pos   = 0;
        end else begin
            k = pos / 4;
            if ((pos % 4) == 3) begin
                e.an  = 4'b1111;
                e.seg = 7'h7F;
                e.pt  = 1'b1;
            end else begin
                e.an  = ~(4'b0001 << k);
                e.seg = r_tbl[k*7 +: 7];
                e.pt  = ~r_dpt[k];
            end
            if (ld) begin
                r_tbl = ntbl;
                r_dpt = d;
            end
            pos = (pos + 1) % c_FRAME;
        end
        q_exp.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 4'b0000, r_tbl);
    endtask

    exp_t m_e;
    always @(negedge clock) begin
        while (q_exp.size() > 0 && q_exp[0].due <= cyc) begin
            m_e = q_exp.pop_front();
            tests_run = tests_run + 1;
            if (m_e.due < cyc) begin
                tests_failed = tests_failed + 1;
                $display("FAIL stale_entry due=%0d cyc=%0d", m_e.due, cyc);
            end else if (anodes !== m_e.an || segments !== m_e.seg || point !== m_e.pt) begin
                tests_failed = tests_failed + 1;
                $display("FAIL display cyc=%0d got an=%b seg=%h pt=%b exp an=%b seg=%h pt=%b",
                         cyc, anodes, segments, point, m_e.an, m_e.seg, m_e.pt);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        value   = 16'h0000;
        dp      = 4'b0000;
        r_tbl   = c_TBL_ZERO;
        r_dpt   = 4'b0000;
        pos     = 0;
        @(posedge clock);
        #1;

        // Reset held, then release with a load of 1A8F / dp on digit 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 4'b0000, c_TBL_ZERO);
        step(1'b1, 1'b1, 16'h1A8F, 4'b0001, c_TBL_1A8F);

        // Two free-running frames: order, dwell and blank slots.
        idle(2 * c_FRAME);

        // Load while digit 0 is lit (pos 1): next cycle shows 30, no blank.
        while (pos != 1) idle(1);
        step(1'b1, 1'b1, 16'h0003, 4'b0000, c_TBL_0003);
        idle(c_FRAME);

        // Fill everything, then reset while digit 2 is lit.
        step(1'b1, 1'b1, 16'hFFFF, 4'b1111, c_TBL_FFFF);
        while (pos != 9) idle(1);
        step(1'b0, 1'b0, 16'hFFFF, 4'b1111, c_TBL_ZERO);
        step(1'b0, 1'b0, 16'hFFFF, 4'b1111, c_TBL_ZERO);
        idle(c_FRAME);

        // Leading-zero handling.
        step(1'b1, 1'b1, 16'h0040, 4'b0000, c_TBL_0040);
        idle(c_FRAME);
        step(1'b1, 1'b1, 16'h0000, 4'b0000, c_TBL_ZERO);
        idle(c_FRAME);

        // Let the monitor drain the last entries.
        repeat (3) @(posedge clock);
        #1;
        tests_run = tests_run + 1;
        if (q_exp.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL drain left=%0d required=0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
